// File: rtl/nibble_deswapper_rx.sv
// Reassembles nibble pairs from the link into bytes, undoes per-byte nibble swapping and
// buffers the bytes in a small FIFO. Defining SYNC_ERR_CNT_EN adds the saturating err_cnt output.
module nibble_deswapper_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    nib_in,
    input  logic                          nib_valid,
    input  logic                          nib_first,
    input  logic                          nib_swapped,
    output logic                          nib_ready,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef SYNC_ERR_CNT_EN
    output logic [CNT_W-1:0]              err_cnt,
`endif
    output logic                          sync_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HALF = 1'b1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
        $error("nibble_deswapper_rx: FIFO_DEPTH must be a power of two >= 2 and CNT_W >= 1");
    end

    logic [0:0]       state_r;
    logic [3:0]       hold_nib_r;
    logic             hold_swp_r;
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             sync_err_r;

    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             err_s;
    logic [7:0]       byte_s;

    // Readiness depends only on registered state, never on out_ready.
    assign nib_ready  = (state_r == IDLE) || (count_r < DEPTH_C);
    assign accept_s   = nib_valid && nib_ready;
    assign out_valid  = (count_r != {(PTR_W+1){1'b0}});
    assign pop_s      = out_valid && out_ready;
    assign out_data   = mem_r[rd_ptr_r];
    assign fifo_count = count_r;
    assign sync_err   = sync_err_r;

    // A swapped byte arrived upper nibble first, so the second nibble goes on top.
    assign byte_s = hold_swp_r ? {nib_in, hold_nib_r} : {hold_nib_r, nib_in};

    // Classify an accepted nibble as a byte completion or a framing error.
    always_comb begin
        push_s = 1'b0;
        err_s  = 1'b0;
        if (accept_s) begin
            case (state_r)
                IDLE: err_s = !nib_first;
                HALF: begin
                    push_s = !nib_first;
                    err_s  = nib_first;
                end
                default: begin
                    push_s = 1'b0;
                    err_s  = 1'b0;
                end
            endcase
        end else begin
            push_s = 1'b0;
            err_s  = 1'b0;
        end
    end

    // Framing FSM and first-nibble hold register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            hold_nib_r <= 4'h0;
            hold_swp_r <= 1'b0;
            sync_err_r <= 1'b0;
        end else begin
            sync_err_r <= err_s;
            if (accept_s) begin
                if (nib_first) begin
                    state_r    <= HALF;
                    hold_nib_r <= nib_in;
                    hold_swp_r <= nib_swapped;
                end else begin
                    state_r    <= IDLE;
                end
            end
        end
    end

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= byte_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef SYNC_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_r;
    assign err_cnt = err_cnt_r;

    // Saturating count of framing-error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (sync_err_r && (err_cnt_r != {CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_nibble_deswapper_rx.sv
// Self-checking bench for nibble_deswapper_rx: vector table, directed corner sequences and
// random traffic compared against a queue-based reference model.
module tb_nibble_deswapper_rx;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef SYNC_ERR_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    nib_in = 4'h0;
    logic          nib_valid = 1'b0;
    logic          nib_first = 1'b0;
    logic          nib_swapped = 1'b0;
    logic          nib_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] fifo_count;
    logic          sync_err;
`ifdef SYNC_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;
`endif

    always #5 clk = ~clk;

    nibble_deswapper_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .nib_in(nib_in), .nib_valid(nib_valid),
        .nib_first(nib_first), .nib_swapped(nib_swapped), .nib_ready(nib_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count),
`ifdef SYNC_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .sync_err(sync_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: byte queue plus a pending first nibble.
    logic [7:0] q[$];
    bit         have = 1'b0;
    logic [3:0] f_nib = 4'h0;
    bit         f_swp = 1'b0;
    bit         m_err = 1'b0;
    int         m_cnt = 0;
    logic [7:0] got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic f, input logic s, input logic [3:0] n,
                         input logic r, input logic rst, output logic acc);
        bit ready_m;
        nib_in = n; nib_valid = v; nib_first = f; nib_swapped = s;
        out_ready = r; reset = rst;
        ready_m = !have || (q.size() < DEPTH);
        acc = v && ready_m && !rst;
        if (rst) begin
            q.delete(); have = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (m_err && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            m_err = acc && (have ? f : !f);
            if (q.size() > 0 && r) q.delete(0);
            if (acc) begin
                if (f) begin
                    have = 1'b1; f_nib = n; f_swp = s;
                end else if (have) begin
                    q.push_back(f_swp ? {n, f_nib} : {f_nib, n});
                    have = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) chk("out_data", {24'd0, out_data}, {24'd0, q[0]});
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("nib_ready", {31'd0, nib_ready}, {31'd0, (!have || q.size() < DEPTH)});
        chk("sync_err", {31'd0, sync_err}, {31'd0, m_err});
`ifdef SYNC_ERR_CNT_EN
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
    endtask

    typedef struct {
        logic [3:0] nib;
        logic       v, f, s;
        logic       exp_ov;
        logic [7:0] exp_od;
        logic       exp_err;
    } vec_t;

    vec_t tbl[12];
    logic acc;
    bit   sent;

    initial begin
        tbl[0]  = '{4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{4'hA, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[2]  = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{4'hC, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0};
        tbl[5]  = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[7]  = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[9]  = '{4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[10] = '{4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h23, 1'b0};
        tbl[11] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

        cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, acc);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, acc);
        chk("reset_out_data", {24'd0, out_data}, 32'h0);
        chk("reset_nib_ready", {31'd0, nib_ready}, 32'h1);

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].v, tbl[i].f, tbl[i].s, tbl[i].nib, 1'b1, 1'b0, acc);
            chk($sformatf("tbl%0d_ov", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_ov});
            if (tbl[i].exp_ov) chk($sformatf("tbl%0d_od", i), {24'd0, out_data}, {24'd0, tbl[i].exp_od});
            chk($sformatf("tbl%0d_err", i), {31'd0, sync_err}, {31'd0, tbl[i].exp_err});
        end

        // Backpressure: fill the FIFO, then a fifth first nibble stalls the second.
        got.delete();
        for (int b = 1; b <= 4; b++) begin
            cycle(1'b1, 1'b1, 1'b0, 4'(b), 1'b0, 1'b0, acc);
            cycle(1'b1, 1'b0, 1'b0, 4'(b), 1'b0, 1'b0, acc);
        end
        cycle(1'b1, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, acc);
        chk("bp_full_count", 32'(fifo_count), 32'd4);
        chk("bp_full_ready", {31'd0, nib_ready}, 32'd0);
        sent = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cycle(!sent, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0, acc);
            if (acc) sent = 1'b1;
        end
        chk("bp_second_accepted", {31'd0, sent}, 32'd1);
        chk("bp_pop_count", 32'(got.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < got.size()) chk($sformatf("bp_pop%0d", k), {24'd0, got[k]}, 32'(8'h11 * (k + 1)));
        end

        // Reset in the middle of a byte drops the partial silently.
        cycle(1'b1, 1'b1, 1'b0, 4'h9, 1'b1, 1'b0, acc);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);
        chk("rst_mid_count", 32'(fifo_count), 32'd0);
        chk("rst_mid_ov", {31'd0, out_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, acc);
        chk("rst_mid_no_err", {31'd0, sync_err}, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0, acc);
        chk("rst_mid_byte", {24'd0, out_data}, 32'h64);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, acc);

`ifdef SYNC_ERR_CNT_EN
        for (int e = 0; e < 5; e++) cycle(1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 1'b0, acc);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, acc);
        chk("err_cnt_sat", 32'(err_cnt), 32'd3);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);
        chk("err_cnt_reset", 32'(err_cnt), 32'd0);
`endif

        // Random traffic with occasional framing errors and bursty backpressure.
        for (int r = 0; r < 600; r++) begin
            logic f;
            f = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : !have;
            cycle(1'($urandom_range(0, 3) != 0), f, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0), 1'b0, acc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_deswapper_rx.md
Name: nibble_deswapper_rx

Overview:
Receive-side counterpart to the byte nibble swapper. It accepts a 4-bit nibble stream from the link, reassembles bytes, and undoes nibble swapping per byte. Reassembled bytes are buffered in a small FIFO and delivered over a valid/ready byte interface. It sits between the nibble link receiver and byte-wide downstream logic.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
CNT_W, 8, width of the sync-error counter; used only with SYNC_ERR_CNT_EN.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
nib_in  input  4  incoming nibble.
nib_valid  input  1  nib_in is valid.
nib_first  input  1  marks the first nibble of a byte.
nib_swapped  input  1  sampled with the first nibble; 1 = the transmitter nibble-swapped this byte.
nib_ready  output  1  block can accept a nibble.
out_data  output  8  restored byte at the FIFO head.
out_valid  output  1  out_data is valid (FIFO not empty).
out_ready  input  1  downstream accepts out_data.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes held.
sync_err  output  1  one-cycle pulse reporting a framing error.

Behaviour:
- Clock and reset: clk is the clock; reset is reset, synchronous and active-high.
- Reset values:
  - state = IDLE, FIFO empty, all FIFO storage cleared.
  - out_valid = 0, out_data = 0x00, fifo_count = 0, sync_err = 0, nib_ready = 1.
- Handshakes:
  - A nibble is accepted when nib_valid && nib_ready.
  - A byte is popped when out_valid && out_ready.
- nib_ready is registered-state only; it never depends combinationally on out_ready.
  - nib_ready = 1 in IDLE.
  - nib_ready = (fifo_count < FIFO_DEPTH) in HALF.
- FSM with states IDLE and HALF:
  - IDLE, accept with nib_first=1: latch the nibble into the hold register and latch nib_swapped; go to HALF.
  - IDLE, accept with nib_first=0: drop the nibble; sync_err pulses the next cycle; stay IDLE.
  - HALF, accept with nib_first=0: form the byte, push it to the FIFO; go to IDLE.
  - HALF, accept with nib_first=1: discard the held partial; sync_err pulses the next cycle; the new nibble becomes the held first nibble and swap flag; stay HALF.
- Byte formation (F = first nibble, S = second nibble):
  - Swapped flag = 1: byte = {S, F}. The transmitter sends the swapped byte upper nibble first.
  - Swapped flag = 0: byte = {F, S}.
- Latency: a byte completed at clock edge N is visible with out_valid=1 after edge N; it is poppable in cycle N+1.
- FIFO rules:
  - In-order delivery.
  - A push into an empty FIFO does not bypass to the output in the same cycle.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push is impossible when full, because nib_ready=0 in HALF.
  - out_data is held stable while out_valid=1 and out_ready=0.
- Reset mid-byte discards the held partial and all FIFO contents; sync_err is not asserted for it.
- Unaccepted nibbles (nib_valid=0, or nib_ready=0) have no effect.

Optional Feature:
SYNC_ERR_CNT_EN
- Defined:
  - Adds output err_cnt [CNT_W-1:0], cleared by reset.
  - err_cnt increments by 1 on each sync_err pulse and saturates at all-ones.
- Not defined: the err_cnt port and counter are absent; all other behaviour is identical.

Test Plan:
- Swapped byte: first 0x5 (nib_first=1, nib_swapped=1), then 0xA, out_ready=1 → out_data=0xA5, out_valid high for one cycle, starting the cycle after the second accept.
- Unswapped byte: first 0x3 (nib_swapped=0), then 0xC → out_data=0x3C; sync_err stays 0.
- Backpressure, FIFO_DEPTH=4, out_ready=0, send bytes 0x11,0x22,0x33,0x44,0x55 unswapped:
  - fifo_count=4 and nib_ready=0 after the 5th first nibble.
  - Raise out_ready → 0x11..0x44 pop in order, the 5th second nibble is accepted, then 0x55 appears.
- Framing errors:
  - Lone nibble 0x7 with nib_first=0 in IDLE → one sync_err pulse, no byte.
  - Sequence 0x1(first), 0x2(first, swapped=0), 0x3 → one sync_err pulse, single output 0x23.
- Reset mid-byte: first nibble 0x9 accepted, reset for one cycle → fifo_count=0, out_valid=0, no sync_err; then 0x4(first, swapped=1), 0x6 → 0x64.
- With SYNC_ERR_CNT_EN and CNT_W=2: five framing errors → err_cnt = 1,2,3,3,3; reset → 0.
